// File: rtl/pool_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : pool_scheduler
// Purpose : 2x2 stride-2 max-pool sequencer. It reads each window from an
//           input map memory, keeps a running signed maximum and writes one
//           pooled element per window to an output memory. The write side
//           uses a valid/ready handshake.
// Options : define POOL_RELU_FUSE_EN to clamp negative maxima to zero on
//           write. Timing is the same whether or not it is defined.
// Revision: 1.0 - initial release
// ============================================================================
module pool_scheduler #(
    parameter int IN_WIDTH  = 28,
    parameter int OUT_WIDTH = 14,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic signed [DATA_W-1:0] rd_data,
    output logic                     wr_en,
    input  logic                     wr_ready,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic signed [DATA_W-1:0] wr_data
);

    localparam logic [ADDR_W-1:0] c_IN_WIDTH  = ADDR_W'(IN_WIDTH);
    localparam logic [ADDR_W-1:0] c_OUT_WIDTH = ADDR_W'(OUT_WIDTH);
    localparam logic [ADDR_W-1:0] c_OUT_LAST  = ADDR_W'(OUT_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                    r_state;
    logic [1:0]                r_tap;
    logic [ADDR_W-1:0]         r_out_x;
    logic [ADDR_W-1:0]         r_out_y;
    logic signed [DATA_W-1:0]  r_acc;
    logic                      r_cap_vld;     // rd_data this cycle belongs to a valid tap
    logic                      r_cap_first;   // ...and that tap was tap 0
    logic                      r_busy;
    logic                      r_done;
    logic                      r_rd_en;
    logic [ADDR_W-1:0]         r_rd_addr;
    logic                      r_wr_en;
    logic [ADDR_W-1:0]         r_wr_addr;
    logic signed [DATA_W-1:0]  r_wr_data;

    logic signed [DATA_W-1:0]  w_acc_next;
    logic signed [DATA_W-1:0]  w_out_val;
    logic [ADDR_W-1:0]         w_next_x;
    logic [ADDR_W-1:0]         w_next_y;
    logic                      w_last_win;

    // Row or column of a tap: twice the window index plus the kernel offset.
    function automatic logic [ADDR_W-1:0] f_pos(input logic [ADDR_W-1:0] base, input logic k);
        return (base << 1) + ADDR_W'(k);
    endfunction

    function automatic logic [ADDR_W-1:0] f_tap_addr(input logic [ADDR_W-1:0] oy,
                                                     input logic [ADDR_W-1:0] ox,
                                                     input logic [1:0]        tap);
        return f_pos(oy, tap[1]) * c_IN_WIDTH + f_pos(ox, tap[0]);
    endfunction

    // Taps hanging off the right or bottom edge of an odd-sized map are skipped.
    function automatic logic f_tap_ok(input logic [ADDR_W-1:0] oy,
                                      input logic [ADDR_W-1:0] ox,
                                      input logic [1:0]        tap);
        return (f_pos(oy, tap[1]) < c_IN_WIDTH) && (f_pos(ox, tap[0]) < c_IN_WIDTH);
    endfunction

    assign w_last_win = (r_out_x == c_OUT_LAST) && (r_out_y == c_OUT_LAST);
    assign w_next_x   = (r_out_x == c_OUT_LAST) ? '0 : r_out_x + 1'b1;
    assign w_next_y   = (r_out_x == c_OUT_LAST) ? r_out_y + 1'b1 : r_out_y;

    // Running maximum: tap 0 loads, later taps replace only when strictly greater.
    always_comb begin
        w_acc_next = r_acc;
        if (r_cap_vld && (r_cap_first || (rd_data > r_acc))) begin
            w_acc_next = rd_data;
        end
    end

`ifdef POOL_RELU_FUSE_EN
    // Fused ReLU: a negative maximum is written as zero.
    always_comb begin
        w_out_val = w_acc_next;
        if (w_acc_next[DATA_W-1]) begin
            w_out_val = '0;
        end
    end
`else
    // Raw signed maximum is written unchanged.
    always_comb begin
        w_out_val = w_acc_next;
    end
`endif

    // Sequencer: state, window counters, accumulator and all registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_tap       <= '0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_acc       <= '0;
            r_cap_vld   <= 1'b0;
            r_cap_first <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_acc       <= w_acc_next;
            r_cap_vld   <= (r_state == S_READ) && r_rd_en;
            r_cap_first <= (r_state == S_READ) && (r_tap == 2'd0);
            r_done      <= 1'b0;
            r_rd_en     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_READ;
                        r_busy    <= 1'b1;
                        r_tap     <= 2'd0;
                        r_out_x   <= '0;
                        r_out_y   <= '0;
                        r_rd_en   <= f_tap_ok('0, '0, 2'd0);
                        r_rd_addr <= f_tap_addr('0, '0, 2'd0);
                    end
                end
                S_READ: begin
                    if (r_tap == 2'd3) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_tap     <= r_tap + 2'd1;
                        r_rd_en   <= f_tap_ok(r_out_y, r_out_x, r_tap + 2'd1);
                        r_rd_addr <= f_tap_addr(r_out_y, r_out_x, r_tap + 2'd1);
                    end
                end
                S_DRAIN: begin
                    // Last tap's data lands this cycle; fold it in while loading the write.
                    r_state   <= S_WRITE;
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_out_y * c_OUT_WIDTH + r_out_x;
                    r_wr_data <= w_out_val;
                end
                S_WRITE: begin
                    if (wr_ready) begin
                        r_wr_en <= 1'b0;
                        if (w_last_win) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= S_READ;
                            r_tap     <= 2'd0;
                            r_out_x   <= w_next_x;
                            r_out_y   <= w_next_y;
                            r_rd_en   <= f_tap_ok(w_next_y, w_next_x, 2'd0);
                            r_rd_addr <= f_tap_addr(w_next_y, w_next_x, 2'd0);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign rd_en   = r_rd_en;
    assign rd_addr = r_rd_addr;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_pool_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_pool_scheduler
// Purpose : Self-checking bench for pool_scheduler. A 28x28 instance runs
//           directed, table-driven and randomized maps against a window-max
//           reference model; a 5x5 -> 3x3 instance covers edge-tap skipping.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pool_scheduler;

    localparam int IN_W = 28;
    localparam int N    = 14;
    localparam int NWIN = N * N;
    localparam int IN_B = 5;
    localparam int N_B  = 3;

    logic clk = 1'b0;
    logic rst_n;

    logic               start, busy, done, rd_en, wr_en, wr_ready;
    logic [15:0]        rd_addr, wr_addr;
    logic signed [31:0] rd_data, wr_data;

    logic               start_b, busy_b, done_b, rd_en_b, wr_en_b, wr_ready_b;
    logic [15:0]        rd_addr_b, wr_addr_b;
    logic signed [31:0] rd_data_b, wr_data_b;

    int mem_a [0:IN_W*IN_W-1];
    int mem_b [0:IN_B*IN_B-1];
    int n_pass  = 0;
    int n_total = 0;
    int got_data[$];

    typedef struct {
        int t0, t1, t2, t3;
        int exp_max;
    } vec_t;
    vec_t tbl[6];

    pool_scheduler dut (
        .clk(clk), .reset(rst_n), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    pool_scheduler #(.IN_WIDTH(IN_B), .OUT_WIDTH(N_B), .DATA_W(32), .ADDR_W(16)) dut_b (
        .clk(clk), .reset(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .wr_en(wr_en_b), .wr_ready(wr_ready_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b)
    );

    always #5 clk = ~clk;

    // Synchronous read memories: data one cycle after the strobe.
    always @(posedge clk) begin
        if (rd_en) rd_data <= (int'(rd_addr) < IN_W*IN_W) ? mem_a[rd_addr] : 32'sd0;
        if (rd_en_b) rd_data_b <= (int'(rd_addr_b) < IN_B*IN_B) ? mem_b[rd_addr_b] : 32'sd0;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int exp_out(input int v);
`ifdef POOL_RELU_FUSE_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    // Reference: maximum over in-range elements of the 2x2 window at (oy, ox).
    function automatic int win_max(input bit use_b, input int in_w, input int oy, input int ox);
        int best, r, c, v;
        bit have;
        best = 0;
        have = 1'b0;
        for (int ky = 0; ky < 2; ky++) begin
            for (int kx = 0; kx < 2; kx++) begin
                r = 2*oy + ky;
                c = 2*ox + kx;
                if (r < in_w && c < in_w) begin
                    if (use_b) v = mem_b[r*in_w + c];
                    else       v = mem_a[r*in_w + c];
                    if (!have || v > best) begin
                        best = v;
                        have = 1'b1;
                    end
                end
            end
        end
        return best;
    endfunction

    function automatic int got(input int k);
        if (k < got_data.size()) return got_data[k];
        return 32'h7fff_fff0;
    endfunction

    // One full map on the 28x28 instance. stall_mode: 0 ready, 1 first write
    // held off 10 cycles, 2 random ready. extra_starts pulses start while busy.
    task automatic run_map(input int stall_mode, input bit extra_starts, input string tag);
        int  exp_d[$];
        int  n_wr, done_cyc, stalls, first_hold;
        bit  prev_stall, fin;
        for (int k = 0; k < NWIN; k++) exp_d.push_back(exp_out(win_max(1'b0, IN_W, k / N, k % N)));
        got_data.delete();
        n_wr = 0; done_cyc = -1; stalls = 0; first_hold = 0; prev_stall = 1'b0; fin = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 3000 && !fin; cyc++) begin
            @(negedge clk);
            case (stall_mode)
                1:       wr_ready = (n_wr != 0) || (first_hold >= 10);
                2:       wr_ready = ($urandom_range(0, 3) != 0);
                default: wr_ready = 1'b1;
            endcase
            start = extra_starts && busy && ($urandom_range(0, 19) == 0);
            if (prev_stall) chk({tag, " wr_en_held"}, wr_en, 1);
            if (wr_en) begin
                if (n_wr < NWIN) begin
                    chk({tag, " wr_addr"}, wr_addr, n_wr);
                    chk({tag, " wr_data"}, wr_data, exp_d[n_wr]);
                end else begin
                    chk({tag, " write_overflow"}, n_wr + 1, NWIN);
                end
                chk({tag, " rd_en_while_writing"}, rd_en, 0);
                if (n_wr == 0) first_hold++;
                if (!wr_ready) stalls++;
                else begin
                    got_data.push_back(wr_data);
                    n_wr++;
                end
            end
            prev_stall = wr_en && !wr_ready;
            if (done) begin
                done_cyc = cyc;
                fin = 1'b1;
            end
        end
        start = 1'b0;
        wr_ready = 1'b1;
        chk({tag, " write_count"}, n_wr, NWIN);
        chk({tag, " done_cycle"}, done_cyc, 6*NWIN + 1 + stalls);
        if (stall_mode == 1) chk({tag, " first_write_hold"}, first_hold, 11);
        @(negedge clk);
        chk({tag, " done_one_cycle"}, done, 0);
        chk({tag, " idle_after_done"}, busy, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nrd, nwr, lw_reads, lw_addr, done_cyc, once, cnt;
        int hits[IN_B*IN_B];

        start = 0; start_b = 0; wr_ready = 1; wr_ready_b = 1; rst_n = 0;
        for (int i = 0; i < IN_W*IN_W; i++) mem_a[i] = i;
        for (int i = 0; i < IN_B*IN_B; i++) mem_b[i] = i;

        tbl[0] = '{-5, -9, -2, -7, -2};
        tbl[1] = '{3, 3, 3, 3, 3};
        tbl[2] = '{1, 2, 3, 4, 4};
        tbl[3] = '{4, 3, 2, 1, 4};
        tbl[4] = '{-1, 5, 32'h8000_0000, 0, 5};
        tbl[5] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0001, 32'h8000_0000, 32'h8000_0001};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst rd_en", rd_en, 0);
        chk("rst wr_en", wr_en, 0);
        chk("rst rd_addr", rd_addr, 0);
        chk("rst wr_addr", wr_addr, 0);
        chk("rst wr_data", wr_data, 0);
        chk("rst busy_b", busy_b, 0);
        rst_n = 1;
        @(negedge clk);

        // Identity memory: pooled value is the bottom-right element of each window
        run_map(0, 1'b0, "ident");
        chk("ident data[0]", got(0), 29);
        chk("ident data[100]", got(100), 2*IN_W*(100/N) + 2*(100%N) + 29);
        chk("ident data[195]", got(195), 783);

        // Table of window (0,0) contents against hand-derived maxima
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < IN_W*IN_W; j++) mem_a[j] = int'($urandom);
            mem_a[0]      = tbl[i].t0;
            mem_a[1]      = tbl[i].t1;
            mem_a[IN_W]   = tbl[i].t2;
            mem_a[IN_W+1] = tbl[i].t3;
            run_map(0, 1'b0, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d first_write", i), got(0), exp_out(tbl[i].exp_max));
        end

        // Back-pressure on the first write, then start pulses while busy
        for (int i = 0; i < IN_W*IN_W; i++) mem_a[i] = i;
        run_map(1, 1'b0, "stall");
        run_map(0, 1'b1, "busy_start");

        // Randomized data, random back-pressure, spurious starts
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < IN_W*IN_W; j++) mem_a[j] = int'($urandom);
            run_map(2, 1'b1, $sformatf("rand%0d", r));
        end

        // Reset during window 50's READ
        for (int i = 0; i < IN_W*IN_W; i++) mem_a[i] = i;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        for (int c = 1; c <= 302; c++) @(negedge clk);
        chk("pre_reset rd_addr", rd_addr, 6*IN_W + 17);
        rst_n = 0;
        @(negedge clk);
        chk("mid_rst busy", busy, 0);
        chk("mid_rst done", done, 0);
        chk("mid_rst rd_en", rd_en, 0);
        chk("mid_rst wr_en", wr_en, 0);
        chk("mid_rst rd_addr", rd_addr, 0);
        chk("mid_rst wr_addr", wr_addr, 0);
        chk("mid_rst wr_data", wr_data, 0);
        rst_n = 1;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (wr_en || busy || rd_en) cnt++;
        end
        chk("post_rst activity", cnt, 0);
        for (int j = 0; j < IN_W*IN_W; j++) mem_a[j] = int'($urandom);
        run_map(0, 1'b0, "post_rst");

        // 5x5 -> 3x3: edge taps skipped, every element read exactly once
        nrd = 0; nwr = 0; lw_reads = 0; lw_addr = -1; done_cyc = -1;
        for (int i = 0; i < IN_B*IN_B; i++) hits[i] = 0;
        start_b = 1;
        @(posedge clk);
        #1 start_b = 0;
        for (int cyc = 1; cyc <= 200 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (rd_en_b) begin
                nrd++;
                if (int'(rd_addr_b) < IN_B*IN_B) hits[rd_addr_b]++;
                if (nwr == N_B*N_B - 1) begin
                    lw_reads++;
                    lw_addr = int'(rd_addr_b);
                end
            end
            if (wr_en_b) begin
                chk("small wr_addr", wr_addr_b, nwr);
                chk("small wr_data", wr_data_b, exp_out(win_max(1'b1, IN_B, nwr / N_B, nwr % N_B)));
                nwr++;
            end
            if (done_b) done_cyc = cyc;
        end
        once = 0;
        for (int i = 0; i < IN_B*IN_B; i++) if (hits[i] == 1) once++;
        chk("small read_count", nrd, 25);
        chk("small each_read_once", once, 25);
        chk("small last_win_reads", lw_reads, 1);
        chk("small last_win_addr", lw_addr, 24);
        chk("small write_count", nwr, N_B*N_B);
        chk("small done_cycle", done_cyc, 6*N_B*N_B + 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
